// File: rtl/vram_arbiter.sv
// vram_arbiter: slot scheduler for the single VRAM port.
// Video reads take a fixed slot in every 8-pixel cell while fetchEn is high.
// Snooped CPU writes wait in a small FIFO and are issued in the free slots.
// This block is the only driver of the VRAM strobes, address and data.
//
// Ports
//   pixClk, reset            pixel clock, synchronous active-high reset
//   seq, fetchEn             cell position (hCount[2:0]), fetch window
//   vidAddr, vidBufSel       video fetch address and displayed buffer
//   vidData, vidDataValid    fetched byte, one-cycle update pulse
//   wrReq/Addr/Data/BufSel   CPU write request (one cycle)
//   wrFull, wrOverflow       FIFO full, sticky dropped-request flag
//   vramAddr/DataOut/DataOE  VRAM address and write data bus
//   vramDataIn               VRAM read data
//   nvramOE/WE/CE0/CE1       active-low VRAM strobes
//
// state       | meaning
// ------------+----------------------------------------------
// S_IDLE      | bus parked, all strobes high
// S_RD1       | video read, OE low, first cycle
// S_RD2       | video read, OE low, data sampled at exit edge
// S_WR_SETUP  | write address/data driven, WE high
// S_WR_STROBE | WE low for one full cycle
// S_WR_HOLD   | address/data held, WE high; FIFO pops at exit

module vram_arbiter #(
   parameter int RD_SLOT    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        pixClk,
   input  logic        reset,
   input  logic [2:0]  seq,
   input  logic        fetchEn,
   input  logic [14:0] vidAddr,
   input  logic        vidBufSel,
   output logic [7:0]  vidData,
   output logic        vidDataValid,
   input  logic        wrReq,
   input  logic [14:0] wrAddr,
   input  logic [7:0]  wrData,
   input  logic        wrBufSel,
   output logic        wrFull,
   output logic        wrOverflow,
   output logic [14:0] vramAddr,
   output logic [7:0]  vramDataOut,
   output logic        vramDataOE,
   input  logic [7:0]  vramDataIn,
   output logic        nvramOE,
   output logic        nvramWE,
   output logic        nvramCE0,
   output logic        nvramCE1
);

   localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              CW      = PW + 1;
   localparam logic [2:0]      SLOT    = 3'(RD_SLOT);
   localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_RD1, S_RD2, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          w_push;
   logic          w_pop;
   logic [23:0]   w_head;

   logic [14:0]   r_rd_addr;
   logic          r_rd_sel;
   logic [14:0]   w_rd_addr;
   logic          w_rd_sel;
   logic [2:0]    w_slot_dist;
   logic          w_rd_go;
   logic          w_wr_blocked;

   logic          r_full;
   logic          r_ovf;
   logic [7:0]    r_vid_data;
   logic          r_vid_valid;
   logic [14:0]   r_addr;
   logic [7:0]    r_dout;
   logic          r_doe;
   logic          r_oe_n;
   logic          r_we_n;
   logic          r_ce0_n;
   logic          r_ce1_n;

   // Push is judged on the registered count, so a full FIFO drops the
   // request even when a pop happens in the same cycle.
   assign w_push = wrReq && (r_count != DEPTH_C);
   assign w_pop  = (r_state == S_WR_HOLD);
   assign w_head = r_mem[r_rd_ptr];

   // A write takes 4 cycles; starting it within two cycles before the read
   // slot would collide with the read launch, so those slots are refused.
   assign w_slot_dist  = SLOT - seq;
   assign w_rd_go      = fetchEn && (seq == SLOT);
   assign w_wr_blocked = fetchEn && (w_slot_dist <= 3'd2);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_rd_go)
               w_state_nxt = S_RD1;
            else if ((r_count != '0) && !w_wr_blocked)
               w_state_nxt = S_WR_SETUP;
            else
               w_state_nxt = S_IDLE;
         end
         S_RD1:       w_state_nxt = S_RD2;
         S_RD2:       w_state_nxt = S_IDLE;
         S_WR_SETUP:  w_state_nxt = S_WR_STROBE;
         S_WR_STROBE: w_state_nxt = S_WR_HOLD;
         S_WR_HOLD:   w_state_nxt = w_rd_go ? S_RD1 : S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - CW'(1);
   end

   // Entering RD1 the address comes straight from the timing generator;
   // in RD2 it comes from the copy captured on the way into RD1.
   assign w_rd_addr = (w_state_nxt == S_RD1) ? vidAddr   : r_rd_addr;
   assign w_rd_sel  = (w_state_nxt == S_RD1) ? vidBufSel : r_rd_sel;

   always_ff @(posedge pixClk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {wrBufSel, wrAddr, wrData};
   end

   always_ff @(posedge pixClk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_full      <= 1'b0;
         r_ovf       <= 1'b0;
         r_vid_data  <= 8'h00;
         r_vid_valid <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_sel    <= 1'b0;
         r_addr      <= '0;
         r_dout      <= 8'h00;
         r_doe       <= 1'b0;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_ce0_n     <= 1'b1;
         r_ce1_n     <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == DEPTH_C);
         if (wrReq && !w_push)
            r_ovf <= 1'b1;

         r_vid_valid <= (r_state == S_RD2);
         if (r_state == S_RD2)
            r_vid_data <= vramDataIn;
         if (w_state_nxt == S_RD1) begin
            r_rd_addr <= vidAddr;
            r_rd_sel  <= vidBufSel;
         end

         // Strobes are registered from the next state so they change
         // cleanly on the edge that enters each state.
         case (w_state_nxt)
            S_RD1, S_RD2: begin
               r_addr  <= w_rd_addr;
               r_dout  <= 8'h00;
               r_doe   <= 1'b0;
               r_oe_n  <= 1'b0;
               r_we_n  <= 1'b1;
               r_ce0_n <= w_rd_sel;
               r_ce1_n <= ~w_rd_sel;
            end
            S_WR_SETUP, S_WR_STROBE, S_WR_HOLD: begin
               r_addr  <= w_head[22:8];
               r_dout  <= w_head[7:0];
               r_doe   <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= (w_state_nxt != S_WR_STROBE);
               r_ce0_n <= w_head[23];
               r_ce1_n <= ~w_head[23];
            end
            default: begin
               r_addr  <= '0;
               r_dout  <= 8'h00;
               r_doe   <= 1'b0;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_ce0_n <= 1'b1;
               r_ce1_n <= 1'b1;
            end
         endcase
      end
   end

   assign vidData      = r_vid_data;
   assign vidDataValid = r_vid_valid;
   assign wrFull       = r_full;
   assign wrOverflow   = r_ovf;
   assign vramAddr     = r_addr;
   assign vramDataOut  = r_dout;
   assign vramDataOE   = r_doe;
   assign nvramOE      = r_oe_n;
   assign nvramWE      = r_we_n;
   assign nvramCE0     = r_ce0_n;
   assign nvramCE1     = r_ce1_n;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter. Stimulus pushes expected reads and
// writes into queues; a negedge monitor pops them whenever the DUT strobes.
module tb_vram_arbiter;
   localparam int RD_SLOT    = 0;
   localparam int FIFO_DEPTH = 4;

   logic        pixClk = 1'b0;
   logic        reset;
   logic [2:0]  seq;
   logic        fetchEn;
   logic [14:0] vidAddr;
   logic        vidBufSel;
   logic [7:0]  vidData;
   logic        vidDataValid;
   logic        wrReq;
   logic [14:0] wrAddr;
   logic [7:0]  wrData;
   logic        wrBufSel;
   logic        wrFull;
   logic        wrOverflow;
   logic [14:0] vramAddr;
   logic [7:0]  vramDataOut;
   logic        vramDataOE;
   logic [7:0]  vramDataIn;
   logic        nvramOE;
   logic        nvramWE;
   logic        nvramCE0;
   logic        nvramCE1;

   always #20 pixClk = ~pixClk;

   vram_arbiter #(.RD_SLOT(RD_SLOT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .pixClk(pixClk), .reset(reset), .seq(seq), .fetchEn(fetchEn),
      .vidAddr(vidAddr), .vidBufSel(vidBufSel), .vidData(vidData),
      .vidDataValid(vidDataValid), .wrReq(wrReq), .wrAddr(wrAddr),
      .wrData(wrData), .wrBufSel(wrBufSel), .wrFull(wrFull),
      .wrOverflow(wrOverflow), .vramAddr(vramAddr), .vramDataOut(vramDataOut),
      .vramDataOE(vramDataOE), .vramDataIn(vramDataIn), .nvramOE(nvramOE),
      .nvramWE(nvramWE), .nvramCE0(nvramCE0), .nvramCE1(nvramCE1)
   );

   // seq = 4'hF means the strobe may land on any cell position
   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
      logic        sel;
      logic [3:0]  seq;
   } exp_t;

   exp_t        wr_q[$];
   exp_t        rd_q[$];
   int          errors = 0;
   int          checks = 0;
   logic        mon_en = 1'b0;
   logic [14:0] vid_base;
   logic [7:0]  vdin;

   assign vramDataIn = vdin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got a strobe, want none (t=%0t)", name, $time);
   endtask

   // ---------------- monitor ----------------
   logic [14:0] p_addr;
   logic [7:0]  p_dout;
   logic        p_doe;
   logic        p_reset;
   logic        hold_pend = 1'b0;
   exp_t        held;

   always @(negedge pixClk) begin
      exp_t e;
      if (mon_en) begin
         chk("oe_we_overlap", 32'(!nvramOE && !nvramWE), 32'(0));
         chk("dual_ce", 32'(!nvramCE0 && !nvramCE1), 32'(0));

         if (hold_pend) begin
            if (!p_reset)
               chk("wr_hold_stable", 32'({vramAddr, vramDataOut, vramDataOE}),
                   32'({held.addr, held.data, 1'b1}));
            hold_pend = 1'b0;
         end

         if (nvramWE === 1'b0) begin
            if (wr_q.size() == 0) unexpected("wr_unexpected");
            else begin
               e = wr_q.pop_front();
               chk("wr_addr", 32'(vramAddr), 32'(e.addr));
               chk("wr_data", 32'(vramDataOut), 32'(e.data));
               chk("wr_doe", 32'(vramDataOE), 32'(1));
               chk("wr_ce", 32'({nvramCE1, nvramCE0}), e.sel ? 32'(2'b01) : 32'(2'b10));
               chk("wr_setup_stable", 32'({p_addr, p_dout, p_doe}), 32'({e.addr, e.data, 1'b1}));
               if (e.seq != 4'hF) chk("wr_seq", 32'(seq), 32'(e.seq));
               held      = e;
               hold_pend = 1'b1;
            end
         end

         if (nvramOE === 1'b0) begin
            if (rd_q.size() == 0) unexpected("rd_unexpected");
            else begin
               e = rd_q[0];
               chk("rd_addr", 32'(vramAddr), 32'(e.addr));
               chk("rd_ce", 32'({nvramCE1, nvramCE0}), e.sel ? 32'(2'b01) : 32'(2'b10));
               chk("rd_oe_seq", 32'(seq == 3'(RD_SLOT + 1) || seq == 3'(RD_SLOT + 2)), 32'(1));
            end
         end

         if (vidDataValid === 1'b1) begin
            if (rd_q.size() == 0) unexpected("rd_valid_unexpected");
            else begin
               e = rd_q.pop_front();
               chk("rd_data", 32'(vidData), 32'(e.data));
               chk("rd_valid_seq", 32'(seq), 32'(3'(RD_SLOT + 3)));
            end
         end
      end
      p_addr  = vramAddr;
      p_dout  = vramDataOut;
      p_doe   = vramDataOE;
      p_reset = reset;
   end

   // ---------------- stimulus ----------------
   task automatic cycle();
      exp_t e;
      vidAddr = vid_base ^ {12'b0, seq};
      if (fetchEn && seq == 3'(RD_SLOT)) begin
         e.addr = vidAddr;
         e.data = vdin;
         e.sel  = vidBufSel;
         e.seq  = 4'hF;
         rd_q.push_back(e);
      end
      @(posedge pixClk);
      #1;
      seq   = seq + 3'd1;
      wrReq = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic push_wr(input logic [14:0] a, input logic [7:0] d, input logic s,
                          input logic [3:0] es, input bit expect_it);
      exp_t e;
      wrReq    = 1'b1;
      wrAddr   = a;
      wrData   = d;
      wrBufSel = s;
      if (expect_it) begin
         e = {a, d, s, es};
         wr_q.push_back(e);
      end
      cycle();
   endtask

   initial begin
      reset = 1'b1; seq = 3'd0; fetchEn = 1'b0; vidAddr = '0; vidBufSel = 1'b0;
      wrReq = 1'b0; wrAddr = '0; wrData = '0; wrBufSel = 1'b0;
      vid_base = '0; vdin = 8'h00;
      repeat (2) @(posedge pixClk);
      #1;
      chk("rst_strobes", 32'({nvramOE, nvramWE, nvramCE0, nvramCE1}), 32'(4'hF));
      chk("rst_addr", 32'(vramAddr), 32'(0));
      chk("rst_doe", 32'(vramDataOE), 32'(0));
      chk("rst_full", 32'(wrFull), 32'(0));
      chk("rst_ovf", 32'(wrOverflow), 32'(0));
      chk("rst_vid", 32'({vidDataValid, vidData}), 32'(0));

      // reads only: one per cell at seq 1,2, data at seq 3
      reset = 1'b0; mon_en = 1'b1;
      fetchEn = 1'b1; vidBufSel = 1'b1; vid_base = 15'h1234; vdin = 8'hA5;
      run(32);

      // blanking: three writes back-to-back, WE low every 4 cycles
      fetchEn = 1'b0;
      push_wr(15'h0100, 8'h11, 1'b0, 4'd3, 1'b1);
      push_wr(15'h0101, 8'h22, 1'b0, 4'd7, 1'b1);
      push_wr(15'h7FFF, 8'h33, 1'b0, 4'd3, 1'b1);
      chk("blank_full", 32'(wrFull), 32'(0));
      run(13);

      // active: write pushed at seq 6 must wait until seq 5 of next cell
      fetchEn = 1'b1; vidBufSel = 1'b0; vid_base = 15'h0456; vdin = 8'h5A;
      run(6);
      push_wr(15'h2222, 8'h44, 1'b1, 4'd5, 1'b1);
      run(9);

      // fill to full, fifth request dropped, drain one per cell
      run(6);
      push_wr(15'h0A01, 8'hA1, 1'b0, 4'd5, 1'b1);
      push_wr(15'h0B02, 8'hB2, 1'b1, 4'd5, 1'b1);
      push_wr(15'h0C03, 8'hC3, 1'b0, 4'd5, 1'b1);
      push_wr(15'h0D04, 8'hD4, 1'b1, 4'd5, 1'b1);
      chk("fill_full", 32'(wrFull), 32'(1));
      chk("fill_ovf_clear", 32'(wrOverflow), 32'(0));
      push_wr(15'h0E05, 8'hE5, 1'b0, 4'd5, 1'b0);
      chk("drop_ovf", 32'(wrOverflow), 32'(1));
      chk("drop_full", 32'(wrFull), 32'(1));
      run(29);
      chk("drain_full", 32'(wrFull), 32'(0));
      chk("ovf_sticky", 32'(wrOverflow), 32'(1));

      // reset during WR_STROBE: in-flight and queued entries discarded
      fetchEn = 1'b0;
      push_wr(15'h1357, 8'h77, 1'b0, 4'd3, 1'b1);
      push_wr(15'h2468, 8'h88, 1'b1, 4'd0, 1'b0);
      run(1);
      reset = 1'b1;
      run(1);
      chk("rstwr_we", 32'(nvramWE), 32'(1));
      chk("rstwr_doe", 32'(vramDataOE), 32'(0));
      chk("rstwr_full", 32'(wrFull), 32'(0));
      chk("rstwr_ovf", 32'(wrOverflow), 32'(0));
      reset = 1'b0;
      run(12);

      // push coinciding with pop at count 2
      push_wr(15'h0001, 8'h01, 1'b1, 4'd3, 1'b1);
      run(2);
      push_wr(15'h4000, 8'hFE, 1'b0, 4'd7, 1'b1);
      push_wr(15'h7FFE, 8'h80, 1'b1, 4'd3, 1'b1);
      chk("pushpop_full", 32'(wrFull), 32'(0));
      run(20);

      chk("rd_queue_empty", 32'(rd_q.size()), 32'(0));
      chk("wr_queue_empty", 32'(wr_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
